// File: rtl/core_sequencer_pkg.sv
// rtl/core_sequencer_pkg.sv - state encodings, fault codes and decode helpers for the core sequencer
package core_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_FETCH     = 3'd1,
    ST_DECODE    = 3'd2,
    ST_EXECUTE   = 3'd3,
    ST_MEMORY    = 3'd4,
    ST_WRITEBACK = 3'd5,
    ST_HALT      = 3'd6
  } state_e;

  typedef enum logic [1:0] {
    FAULT_NONE    = 2'b00,
    FAULT_ILLEGAL = 2'b01,
    FAULT_IMEM    = 2'b10,
    FAULT_DMEM    = 2'b11
  } fault_e;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  // A decoded instruction must belong to exactly one class.
  function automatic logic class_onehot(input logic [4:0] flags);
    return (flags != 5'd0) && ((flags & (flags - 5'd1)) == 5'd0);
  endfunction

endpackage

// File: rtl/core_sequencer_mem_wait_timer.sv
// rtl/core_sequencer_mem_wait_timer.sv - 8-bit memory wait counter with clear, enable and expiry flag
module mem_wait_timer
  import core_sequencer_pkg::*;
#(
  parameter logic [7:0] LIMIT = 8'd15
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic expired
);

  logic [7:0] count_q;
  logic [7:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = 8'd0;
    end else if (en) begin
      count_d = count_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= 8'd0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired = (count_q == LIMIT);

endmodule

// File: rtl/core_sequencer.sv
// rtl/core_sequencer.sv - multi-cycle fetch/decode/execute/memory/writeback control FSM
module core_sequencer
  import core_sequencer_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = DEFAULT_RESET_PC,
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        run,
  input  logic        imem_ready,
  input  logic        dmem_ready,
  input  logic        is_load,
  input  logic        is_store,
  input  logic        is_branch,
  input  logic        is_jump,
  input  logic        is_alu,
  input  logic [4:0]  dest,
  input  logic [31:0] next_pc,
  output logic        imem_req,
  output logic        ir_we,
  output logic        decode_en,
  output logic        exec_en,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic        reg_we,
  output logic [31:0] pc,
  output logic [31:0] retired,
  output logic        halted,
  output logic [1:0]  fault
);

  localparam logic [7:0] TIMEOUT_LIMIT = MEM_TIMEOUT[7:0];

  state_e      state_q, state_d;
  fault_e      fault_q, fault_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] retired_q, retired_d;
  logic        imem_req_q, imem_req_d;
  logic        decode_en_q, decode_en_d;
  logic        exec_en_q, exec_en_d;
  logic        dmem_req_q, dmem_req_d;
  logic        dmem_we_q, dmem_we_d;
  logic        halted_q, halted_d;
  logic        timer_clr, timer_en, timer_expired;

  mem_wait_timer #(.LIMIT(TIMEOUT_LIMIT)) u_wait_timer (
    .clk     (clk),
    .reset   (reset),
    .clr     (timer_clr),
    .en      (timer_en),
    .expired (timer_expired)
  );

  always_comb begin
    state_d   = state_q;
    fault_d   = fault_q;
    pc_d      = pc_q;
    retired_d = retired_q;
    case (state_q)
      ST_IDLE:    if (run) state_d = ST_FETCH;
      ST_FETCH: begin
        if (imem_ready) begin
          state_d = ST_DECODE;
        end else if (timer_expired) begin
          state_d = ST_HALT;
          fault_d = FAULT_IMEM;
        end
      end
      ST_DECODE: begin
        if (class_onehot({is_load, is_store, is_branch, is_jump, is_alu})) begin
          state_d = ST_EXECUTE;
        end else begin
          state_d = ST_HALT;
          fault_d = FAULT_ILLEGAL;
        end
      end
      ST_EXECUTE: state_d = (is_load || is_store) ? ST_MEMORY : ST_WRITEBACK;
      ST_MEMORY: begin
        if (dmem_ready) begin
          state_d = ST_WRITEBACK;
        end else if (timer_expired) begin
          state_d = ST_HALT;
          fault_d = FAULT_DMEM;
        end
      end
      ST_WRITEBACK: begin
        pc_d      = next_pc;
        retired_d = retired_q + 32'd1;
        state_d   = run ? ST_FETCH : ST_IDLE;
      end
      ST_HALT:    state_d = ST_HALT;
      default:    state_d = ST_IDLE;
    endcase

    // Counter restarts on every state change and only runs while a memory is stalling.
    timer_clr = (state_d != state_q);
    timer_en  = ((state_q == ST_FETCH) && !imem_ready) || ((state_q == ST_MEMORY) && !dmem_ready);

    imem_req_d  = (state_d == ST_FETCH);
    decode_en_d = (state_d == ST_DECODE);
    exec_en_d   = (state_d == ST_EXECUTE);
    dmem_req_d  = (state_d == ST_MEMORY);
    dmem_we_d   = (state_d == ST_MEMORY) && is_store;
    halted_d    = (state_d == ST_HALT);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      fault_q     <= FAULT_NONE;
      pc_q        <= RESET_PC;
      retired_q   <= 32'd0;
      imem_req_q  <= 1'b0;
      decode_en_q <= 1'b0;
      exec_en_q   <= 1'b0;
      dmem_req_q  <= 1'b0;
      dmem_we_q   <= 1'b0;
      halted_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      fault_q     <= fault_d;
      pc_q        <= pc_d;
      retired_q   <= retired_d;
      imem_req_q  <= imem_req_d;
      decode_en_q <= decode_en_d;
      exec_en_q   <= exec_en_d;
      dmem_req_q  <= dmem_req_d;
      dmem_we_q   <= dmem_we_d;
      halted_q    <= halted_d;
    end
  end

  // dest only becomes valid once execute has registered it, so reg_we is decoded live.
  assign reg_we    = (state_q == ST_WRITEBACK) && (is_alu || is_load || is_jump) && (dest != 5'd0);
  assign ir_we     = imem_req_q && imem_ready;
  assign imem_req  = imem_req_q;
  assign decode_en = decode_en_q;
  assign exec_en   = exec_en_q;
  assign dmem_req  = dmem_req_q;
  assign dmem_we   = dmem_we_q;
  assign halted    = halted_q;
  assign pc        = pc_q;
  assign retired   = retired_q;
  assign fault     = fault_q;

endmodule

// File: tb/tb_core_sequencer.sv
// tb/tb_core_sequencer.sv - directed self-checking bench for core_sequencer
module tb_core_sequencer;

  logic        clk = 1'b0;
  logic        reset, run, imem_ready, dmem_ready;
  logic        is_load, is_store, is_branch, is_jump, is_alu;
  logic [4:0]  dest;
  logic [31:0] next_pc;
  logic        imem_req, ir_we, decode_en, exec_en, dmem_req, dmem_we, reg_we, halted;
  logic [31:0] pc, retired;
  logic [1:0]  fault;

  int n_checks = 0;
  int n_fail   = 0;
  int hits;

  core_sequencer #(.RESET_PC(32'h0000_0000), .MEM_TIMEOUT(15)) dut (
    .clk(clk), .reset(reset), .run(run), .imem_ready(imem_ready), .dmem_ready(dmem_ready),
    .is_load(is_load), .is_store(is_store), .is_branch(is_branch), .is_jump(is_jump),
    .is_alu(is_alu), .dest(dest), .next_pc(next_pc), .imem_req(imem_req), .ir_we(ir_we),
    .decode_en(decode_en), .exec_en(exec_en), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .reg_we(reg_we), .pc(pc), .retired(retired), .halted(halted), .fault(fault)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // {load, store, branch, jump, alu}
  task automatic set_class(input logic [4:0] f);
    {is_load, is_store, is_branch, is_jump, is_alu} = f;
  endtask

  initial begin
    reset = 1'b1; run = 1'b0; imem_ready = 1'b0; dmem_ready = 1'b0;
    set_class(5'b00000); dest = 5'd0; next_pc = 32'd0;
    step(); step();
    check("rst_pc", pc, 32'h0);
    check("rst_retired", retired, 32'd0);
    check("rst_fault", {30'd0, fault}, 32'd0);
    check("rst_halted", {31'd0, halted}, 32'd0);
    check("rst_imem_req", {31'd0, imem_req}, 32'd0);
    reset = 1'b0;
    step();
    check("idle_no_req", {31'd0, imem_req}, 32'd0);

    // ALU op, zero-wait fetch, dest=5; run dropped mid-instruction
    set_class(5'b00001); dest = 5'd5; next_pc = 32'h100; imem_ready = 1'b1; run = 1'b1;
    step();
    check("alu_c1_imem_req", {31'd0, imem_req}, 32'd1);
    check("alu_c1_ir_we", {31'd0, ir_we}, 32'd1);
    run = 1'b0;
    step();
    check("alu_c2_decode_en", {31'd0, decode_en}, 32'd1);
    check("alu_c2_ir_we", {31'd0, ir_we}, 32'd0);
    step();
    check("alu_c3_exec_en", {31'd0, exec_en}, 32'd1);
    step();
    check("alu_c4_reg_we", {31'd0, reg_we}, 32'd1);
    check("alu_c4_pc_old", pc, 32'h0);
    step();
    check("alu_pc", pc, 32'h100);
    check("alu_retired", retired, 32'd1);
    check("alu_idle", {31'd0, imem_req}, 32'd0);

    // Store with dmem_ready arriving after three wait cycles
    set_class(5'b01000); dest = 5'd9; next_pc = 32'h104; dmem_ready = 1'b0; run = 1'b1;
    step(); run = 1'b0;
    step(); step();
    hits = 0;
    for (int c = 4; c <= 7; c++) begin
      step();
      if (dmem_req && dmem_we) hits++;
      if (c == 7) dmem_ready = 1'b1;
    end
    check("st_mem_cycles", hits, 32'd4);
    step();
    check("st_c8_reg_we", {31'd0, reg_we}, 32'd0);
    check("st_c8_dmem_req", {31'd0, dmem_req}, 32'd0);
    dmem_ready = 1'b0;
    step();
    check("st_pc", pc, 32'h104);
    check("st_retired", retired, 32'd2);

    // Jump with dest=0, then branch
    set_class(5'b00010); dest = 5'd0; next_pc = 32'h80; run = 1'b1;
    step(); run = 1'b0;
    step(); step(); step();
    check("jmp_reg_we", {31'd0, reg_we}, 32'd0);
    step();
    check("jmp_pc", pc, 32'h80);
    set_class(5'b00100); dest = 5'd7; next_pc = 32'h40; run = 1'b1;
    step(); run = 1'b0;
    step(); step(); step();
    check("br_reg_we", {31'd0, reg_we}, 32'd0);
    step();
    check("br_pc", pc, 32'h40);
    check("br_retired", retired, 32'd4);

    // Reset while a load is stalled in MEMORY
    set_class(5'b10000); dest = 5'd3; next_pc = 32'h300; run = 1'b1;
    step(); run = 1'b0;
    step(); step(); step();
    check("ld_dmem_req", {31'd0, dmem_req}, 32'd1);
    check("ld_dmem_we", {31'd0, dmem_we}, 32'd0);
    reset = 1'b1;
    step();
    check("rstmem_dmem_req", {31'd0, dmem_req}, 32'd0);
    check("rstmem_pc", pc, 32'h0);
    check("rstmem_retired", retired, 32'd0);
    reset = 1'b0;
    step();
    check("rstmem_idle", {31'd0, imem_req}, 32'd0);

    // Retired counter wraps from all-ones
    force dut.retired_q = 32'hFFFF_FFFF;
    step();
    release dut.retired_q;
    step();
    check("wrap_preset", retired, 32'hFFFF_FFFF);
    set_class(5'b10000); dest = 5'd3; next_pc = 32'h200; dmem_ready = 1'b1; run = 1'b1;
    step(); run = 1'b0;
    step(); step(); step();
    check("wrap_dmem_req", {31'd0, dmem_req}, 32'd1);
    step();
    check("wrap_ld_reg_we", {31'd0, reg_we}, 32'd1);
    step();
    check("wrap_retired", retired, 32'd0);
    check("wrap_pc", pc, 32'h200);

    // Illegal decode: no class flag set
    set_class(5'b00000); run = 1'b1;
    step(); step();
    check("ill_decode_en", {31'd0, decode_en}, 32'd1);
    step();
    check("ill_halted", {31'd0, halted}, 32'd1);
    check("ill_fault", {30'd0, fault}, 32'd1);
    check("ill_pc", pc, 32'h200);
    check("ill_retired", retired, 32'd0);
    step();
    check("ill_stays_halted", {31'd0, halted}, 32'd1);
    check("ill_no_req", {31'd0, imem_req}, 32'd0);

    // imem never ready: fault after the expiry cycle
    reset = 1'b1; step(); reset = 1'b0;
    set_class(5'b00001); dest = 5'd1; imem_ready = 1'b0; run = 1'b1;
    hits = 0;
    for (int c = 1; c <= 16; c++) begin
      step();
      if (imem_req && !halted) hits++;
    end
    check("ito_req_cycles", hits, 32'd16);
    step();
    check("ito_halted", {31'd0, halted}, 32'd1);
    check("ito_fault", {30'd0, fault}, 32'd2);
    check("ito_req_off", {31'd0, imem_req}, 32'd0);

    // imem ready exactly in the expiry cycle wins
    reset = 1'b1; step(); reset = 1'b0;
    imem_ready = 1'b0; run = 1'b1;
    for (int c = 1; c <= 16; c++) step();
    imem_ready = 1'b1;
    #1;
    check("iexp_ir_we", {31'd0, ir_we}, 32'd1);
    step();
    check("iexp_decode_en", {31'd0, decode_en}, 32'd1);
    check("iexp_halted", {31'd0, halted}, 32'd0);
    check("iexp_fault", {30'd0, fault}, 32'd0);

    // dmem never ready: fault 11
    reset = 1'b1; step(); reset = 1'b0;
    set_class(5'b10000); imem_ready = 1'b1; dmem_ready = 1'b0; run = 1'b1;
    for (int c = 1; c <= 19; c++) step();
    check("dto_c19_dmem_req", {31'd0, dmem_req}, 32'd1);
    check("dto_c19_halted", {31'd0, halted}, 32'd0);
    step();
    check("dto_halted", {31'd0, halted}, 32'd1);
    check("dto_fault", {30'd0, fault}, 32'd3);
    check("dto_dmem_req_off", {31'd0, dmem_req}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
